cordic_request_arbiter: RTL
===========================

Name: cordic_request_arbiter

Overview:
Shares one iterative 8-bit CORDIC engine between two angle requesters. The block arbitrates round-robin, latches the winning angle and drives the engine's seed values and start strobe. It then waits for the engine's done strobe, with a timeout watchdog, and returns the cosine (x) result tagged with the requester ID. It sits between the top-level IO wrapper and the CORDIC datapath.

Parameters:
DATA_WIDTH, 8, width of angle, seed and result words
X_INIT, 8'h4B, x seed driven to the engine (CORDIC gain compensation); y seed is fixed at 0
TIMEOUT_CYCLES, 32, maximum number of WAIT cycles before the engine is declared hung (must be ≥2)

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous active-high reset
req0_valid_i  in  1  requester 0 has an angle pending
req0_z_i  in  DATA_WIDTH  requester 0 angle
req0_ready_o  out  1  requester 0 accepted this cycle when valid and ready are both high
req1_valid_i  in  1  requester 1 has an angle pending
req1_z_i  in  DATA_WIDTH  requester 1 angle
req1_ready_o  out  1  requester 1 accepted this cycle when valid and ready are both high
cordic_x_o  out  DATA_WIDTH  x seed to engine, constant X_INIT
cordic_y_o  out  DATA_WIDTH  y seed to engine, constant 0
cordic_z_o  out  DATA_WIDTH  latched angle to engine
cordic_start_strobe_o  out  1  one-cycle start pulse to engine
cordic_x_i  in  DATA_WIDTH  engine x result
cordic_done_strobe_i  in  1  engine result-valid strobe
rsp_x_o  out  DATA_WIDTH  returned result
rsp_id_o  out  1  requester that owns rsp_x_o
rsp_err_o  out  1  response is a timeout; rsp_x_o is 0
rsp_valid_strobe_o  out  1  one-cycle response pulse
busy_o  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_i=1): state=IDLE, last_id=1 so requester 0 wins the first tie. cordic_z_o=0, start strobe=0, rsp_x_o=0, rsp_id_o=0, rsp_err_o=0, rsp_valid_strobe_o=0, timeout counter=0. cordic_x_o/cordic_y_o are constants and are unaffected by reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, grant (combinational):
  - only req0 valid: grant 0.
  - only req1 valid: grant 1.
  - both valid: grant !last_id.
  - reqN_ready_o = (state==IDLE) && grant==N. At most one ready is high; neither is high outside IDLE.
- Accept at a clock edge where valid && ready:
  - latch reqN_z_i into cordic_z_o.
  - owner<=N, last_id<=N, go to ISSUE.
- ISSUE: cordic_start_strobe_o=1 for exactly this one cycle. cordic_z_o is stable. Clear the timeout counter and go to WAIT.
- WAIT, on cordic_done_strobe_i=1 at an edge:
  - rsp_x_o<=cordic_x_i, rsp_id_o<=owner, rsp_err_o<=0.
  - rsp_valid_strobe_o=1 in the next cycle only; go to IDLE.
- WAIT, no done strobe:
  - counter increments.
  - If counter==TIMEOUT_CYCLES-1 at the edge: rsp_x_o<=0, rsp_id_o<=owner, rsp_err_o<=1, strobe for one cycle, go to IDLE.
  - WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
- Done strobe and timeout at the same edge: done wins and rsp_err_o=0.
- Done strobe while in IDLE or ISSUE: ignored and does not alter rsp_*.
- rsp_x_o, rsp_id_o and rsp_err_o hold their values until the next response.
- Latency:
  - accept edge k: start strobe high during cycle k+1, WAIT from k+2.
  - done sampled at edge m: rsp pulse during cycle m+1.
  - the FSM is back in IDLE during that pulse cycle, so the next accept can occur at edge m+1.
- Requester valid/z may change freely when not accepted. The latched angle is unaffected by later input changes.
- Reset asserted mid-transaction: immediate abort, no response pulse, ownership and round-robin history lost.

Test Plan:
- Reset, then req0 valid with z=8'h20, engine model returns x=8'h6E five cycles after start -> req0_ready_o high in IDLE; start pulse one cycle after accept with cordic_z_o=8'h20; rsp pulse 1 cycle after done with rsp_x_o=8'h6E, rsp_id_o=0, rsp_err_o=0; cordic_x_o=8'h4B and cordic_y_o=0 throughout.
- Both valid continuously (z0=8'h10, z1=8'h40), three transactions -> grants in order 0,1,0; cordic_z_o in order 10,40,10; each rsp_id_o matches its grant.
- Engine never strobes done, TIMEOUT_CYCLES=32 -> exactly 32 WAIT cycles, then rsp pulse with rsp_err_o=1, rsp_x_o=0; busy_o falls in the same cycle as the pulse.
- Done strobe on the final WAIT cycle (counter=31) with x=8'h3C -> rsp_err_o=0, rsp_x_o=8'h3C.
- Spurious done in IDLE and a second done in ISSUE -> no rsp pulse, rsp_x_o unchanged from the prior response.
- rst_i pulsed during WAIT -> all outputs return to reset values asynchronously, no rsp pulse; afterwards both valid -> req0 granted first.

Source files
------------

// File: rtl/cordic_request_arbiter.sv
// rtl/cordic_request_arbiter.sv - round-robin arbiter sharing one CORDIC engine between two requesters
module cordic_request_arbiter #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] X_INIT         = 8'h4B,
    parameter int                    TIMEOUT_CYCLES = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    input  logic [DATA_WIDTH-1:0] req0_z_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [DATA_WIDTH-1:0] req1_z_i,
    output logic                  req1_ready_o,
    output logic [DATA_WIDTH-1:0] cordic_x_o,
    output logic [DATA_WIDTH-1:0] cordic_y_o,
    output logic [DATA_WIDTH-1:0] cordic_z_o,
    output logic                  cordic_start_strobe_o,
    input  logic [DATA_WIDTH-1:0] cordic_x_i,
    input  logic                  cordic_done_strobe_i,
    output logic [DATA_WIDTH-1:0] rsp_x_o,
    output logic                  rsp_id_o,
    output logic                  rsp_err_o,
    output logic                  rsp_valid_strobe_o,
    output logic                  busy_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_id_q, last_id_d;
    logic                    owner_q, owner_d;
    logic [DATA_WIDTH-1:0]   z_q, z_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rsp_x_q, rsp_x_d;
    logic                    rsp_id_q, rsp_id_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_valid_q, rsp_valid_d;

    logic grant;
    logic accept;
    logic done_evt;
    logic timeout_evt;

    // Ties go to the requester that was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_id_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    assign accept      = (state_q == S_IDLE) && (req0_valid_i || req1_valid_i);
    assign done_evt    = (state_q == S_WAIT) && cordic_done_strobe_i;
    assign timeout_evt = (state_q == S_WAIT) && !cordic_done_strobe_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done_evt || timeout_evt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o          = (state_q == S_IDLE) && req0_valid_i && (grant == 1'b0);
        req1_ready_o          = (state_q == S_IDLE) && req1_valid_i && (grant == 1'b1);
        cordic_start_strobe_o = (state_q == S_ISSUE);
        busy_o                = (state_q != S_IDLE);
    end

    always_comb begin
        last_id_d   = last_id_q;
        owner_d     = owner_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        rsp_x_d     = rsp_x_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = 1'b0;
        if (accept) begin
            owner_d   = grant;
            last_id_d = grant;
            z_d       = grant ? req1_z_i : req0_z_i;
        end
        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end
        if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (done_evt) begin
            rsp_x_d     = cordic_x_i;
            rsp_id_d    = owner_q;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
        end else if (timeout_evt) begin
            rsp_x_d     = '0;
            rsp_id_d    = owner_q;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_id_q   <= 1'b1;
            owner_q     <= 1'b0;
            z_q         <= '0;
            cnt_q       <= '0;
            rsp_x_q     <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            last_id_q   <= last_id_d;
            owner_q     <= owner_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            rsp_x_q     <= rsp_x_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cordic_x_o         = X_INIT;
    assign cordic_y_o         = '0;
    assign cordic_z_o         = z_q;
    assign rsp_x_o            = rsp_x_q;
    assign rsp_id_o           = rsp_id_q;
    assign rsp_err_o          = rsp_err_q;
    assign rsp_valid_strobe_o = rsp_valid_q;

endmodule
